// File: rtl/vga_plot_arbiter_pkg.sv
// Shared definitions for the VGA plot arbiter: FSM state encoding and
// default pixel field widths used by the interface and the arbiter.
package vga_plot_arbiter_pkg;

  localparam int DEF_X_W = 9;
  localparam int DEF_Y_W = 9;
  localparam int DEF_C_W = 6;
  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Bus between the drawing clients / VGA adapter (master) and the arbiter (slave).
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int X_W     = vga_plot_arbiter_pkg::DEF_X_W,
  parameter int Y_W     = vga_plot_arbiter_pkg::DEF_Y_W,
  parameter int C_W     = vga_plot_arbiter_pkg::DEF_C_W
);

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     plot_in;
  logic [NUM_REQ*X_W-1:0] x_in;
  logic [NUM_REQ*Y_W-1:0] y_in;
  logic [NUM_REQ*C_W-1:0] colour_in;

  logic [NUM_REQ-1:0]     grant;
  logic                   writeEn;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [C_W-1:0]         colour;
  logic                   busy;
  logic [vga_plot_arbiter_pkg::OWNER_W-1:0] owner;
  logic                   timeout_pulse;

  modport master (
    output req, plot_in, x_in, y_in, colour_in,
    input  grant, writeEn, x, y, colour, busy, owner, timeout_pulse
  );

  modport slave (
    input  req, plot_in, x_in, y_in, colour_in,
    output grant, writeEn, x, y, colour, busy, owner, timeout_pulse
  );

endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Round-robin winner search: first requester found scanning from last+1,
// wrapping modulo NUM_REQ, so the last owner is always considered last.
module rr_pick
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last,
  output logic [OWNER_W-1:0] winner,
  output logic               valid
);

  // Walking offsets from farthest to nearest lets the nearest hit win.
  always_comb begin
    winner = '0;
    valid  = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (((int'(last) + i) % NUM_REQ) == j)) begin
          winner = OWNER_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares one VGA adapter pixel port between NUM_REQ drawing clients, with
// round-robin ownership and a watchdog that revokes silent owners.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W
) (
  input logic              clk,
  input logic              resetn,
  vga_plot_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  arb_state_e         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               write_en_q, write_en_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [C_W-1:0]     colour_q, colour_d;
  logic               timeout_pulse_q, timeout_pulse_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;

  logic [OWNER_W-1:0] pick_winner;
  logic               pick_valid;

  logic               own_req;
  logic               own_plot;
  logic [X_W-1:0]     own_x;
  logic [Y_W-1:0]     own_y;
  logic [C_W-1:0]     own_colour;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (owner_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Only the current owner's lane is ever looked at; other clients are invisible.
  always_comb begin
    own_req    = 1'b0;
    own_plot   = 1'b0;
    own_x      = '0;
    own_y      = '0;
    own_colour = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner_q == OWNER_W'(j)) begin
        own_req    = bus.req[j];
        own_plot   = bus.plot_in[j];
        own_x      = bus.x_in[j*X_W +: X_W];
        own_y      = bus.y_in[j*Y_W +: Y_W];
        own_colour = bus.colour_in[j*C_W +: C_W];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    grant_d         = grant_q;
    write_en_d      = 1'b0;
    x_d             = x_q;
    y_d             = y_q;
    colour_d        = colour_q;
    timeout_pulse_d = 1'b0;
    wdog_d          = wdog_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWN;
          owner_d = pick_winner;
          wdog_d  = '0;
          for (int j = 0; j < NUM_REQ; j++) begin
            grant_d[j] = (pick_winner == OWNER_W'(j));
          end
        end
      end
      ST_OWN: begin
        // A dropped request beats a pending plot: the transaction is over.
        if (!own_req) begin
          state_d = ST_RELEASE;
          grant_d = '0;
        end else if (own_plot) begin
          write_en_d = 1'b1;
          x_d        = own_x;
          y_d        = own_y;
          colour_d   = own_colour;
          wdog_d     = '0;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d         = ST_RELEASE;
          grant_d         = '0;
          timeout_pulse_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWNER_W'(NUM_REQ - 1);
      grant_q         <= '0;
      write_en_q      <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      colour_q        <= '0;
      timeout_pulse_q <= 1'b0;
      wdog_q          <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      grant_q         <= grant_d;
      write_en_q      <= write_en_d;
      x_q             <= x_d;
      y_q             <= y_d;
      colour_q        <= colour_d;
      timeout_pulse_q <= timeout_pulse_d;
      wdog_q          <= wdog_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.writeEn       = write_en_q;
  assign bus.x             = x_q;
  assign bus.y             = y_q;
  assign bus.colour        = colour_q;
  assign bus.busy          = (state_q == ST_OWN);
  assign bus.owner         = owner_q;
  assign bus.timeout_pulse = timeout_pulse_q;

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of drawing clients (2..8).
REQ-002 Parameter TIMEOUT, default 1024, idle cycles before a silent owner is revoked.
REQ-003 Parameters X_W, default 9, and Y_W, default 9: pixel coordinate widths.
REQ-004 Parameter C_W, default 6: colour width.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_REQ  per-client request; held high for the whole drawing transaction.
REQ-008 plot_in  in  NUM_REQ  per-client pixel write strobe.
REQ-009 x_in  in  NUM_REQ*X_W  packed client x; client i occupies bits [i*X_W +: X_W].
REQ-010 y_in  in  NUM_REQ*Y_W  packed client y, same packing.
REQ-011 colour_in  in  NUM_REQ*C_W  packed client colour, same packing.
REQ-012 grant  out  NUM_REQ  one-hot ownership; all zero when no owner.
REQ-013 writeEn  out  1  registered plot strobe to the VGA adapter.
REQ-014 x, y, colour  out  X_W, Y_W, C_W  registered pixel to the VGA adapter.
REQ-015 busy  out  1  high while any client owns the port.
REQ-016 owner  out  3  index of the current or last owner.
REQ-017 timeout_pulse  out  1  one-cycle pulse when an owner is revoked.

Function
REQ-018 The FSM SHALL have states IDLE, OWN and RELEASE.
REQ-019 IDLE: if any req bit is high, select the winner round-robin, scanning from owner+1 and wrapping modulo NUM_REQ; next cycle go to OWN with grant[winner]=1 and owner=winner.
REQ-020 Grant latency from a req rising in IDLE SHALL be exactly 1 cycle.
REQ-021 OWN: writeEn, x, y and colour SHALL register the owner's plot_in, x_in, y_in and colour_in with 1-cycle latency; other clients' inputs are ignored.
REQ-022 OWN: when req[owner] is low, go to RELEASE; grant drops the same edge.
REQ-023 OWN: a watchdog counter SHALL clear on each owner plot_in and on OWN entry, and increment otherwise; at TIMEOUT-1 go to RELEASE and pulse timeout_pulse.
REQ-024 RELEASE: one cycle with grant=0 and writeEn=0, then IDLE; requests are not sampled in RELEASE.
REQ-025 A revoked client still holding req SHALL be granted again only after every other pending requester has been served.
REQ-026 When several requests arrive simultaneously, round-robin order decides; lowest index wins the first arbitration after reset, since owner resets to NUM_REQ-1.
REQ-027 plot_in from a non-owner SHALL never reach writeEn.
REQ-028 busy SHALL equal (state==OWN).
REQ-029 Out-of-range x/y values SHALL pass through unchanged; clipping belongs to the adapter.

Reset
REQ-030 resetn low SHALL asynchronously force IDLE, grant=0, writeEn=0, x=0, y=0, colour=0, busy=0, owner=NUM_REQ-1, timeout_pulse=0 and watchdog=0.
REQ-031 Reset asserted in the middle of a transaction SHALL abandon it; no pixel is emitted on the cycle after reset deassertion.

Structure
REQ-032 A shared package SHALL hold the state encodings and the default X_W, Y_W and C_W.
REQ-033 The round-robin winner search SHALL be a sub-module rr_pick (inputs req and last index; outputs winner index and valid).

Verification
REQ-034 Single client: req[1]=1, then plot_in[1] for 4 pixels at (10,198)..(13,198) -> grant=3'b010 one cycle later; writeEn high 4 cycles, each pixel 1 cycle after its input; drop req -> RELEASE -> IDLE.
REQ-035 Contention: req=3'b111 from reset, each client drops req after 2 plots -> grant order 001, 010, 100; each pair of grants separated by 1 RELEASE cycle.
REQ-036 Isolation: client 0 owns; client 2 drives plot_in=1 with x=5 -> no writeEn with x=5 appears.
REQ-037 Watchdog: TIMEOUT=8, client 0 granted and never plots -> timeout_pulse on the 8th OWN cycle, grant=0; with req=3'b011 held, client 1 is granted next.
REQ-038 Reset mid-operation: resetn pulled low during OWN -> all outputs zero immediately and owner=NUM_REQ-1; after release, req[0]=1 is granted in 1 cycle.
